// File: rtl/clarke.sv
// Amplitude-invariant Clarke transform (a,b,c -> alpha,beta) built around one
// shared multiplier that is sequenced by a five-state FSM.
module clarke #(
   parameter int DATA_W = 18,
   parameter int COEF_W = 18
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [DATA_W-1:0] c,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] alpha,
   output logic signed [DATA_W-1:0] beta,
   output logic                     out_valid,
   output logic                     saturated
);

   localparam int SUMA_W = DATA_W + 3;
   localparam int SUMB_W = DATA_W + 1;
   localparam int PROD_W = DATA_W + COEF_W + 4;
   localparam int RND_W  = DATA_W + 5;

   localparam logic [COEF_W-2:0] K_THIRD     = (COEF_W-1)'(43691);
   localparam logic [COEF_W-2:0] K_INV_SQRT3 = (COEF_W-1)'(75674);

   localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(65536);
   localparam logic signed [RND_W-1:0]  SAT_MAX  = {{6{1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RND_W-1:0]  SAT_MIN  = {{6{1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SUM,
      S_MUL_A,
      S_MUL_B,
      S_OUT
   } state_t;

   state_t r_state;
   state_t w_next;

   logic signed [DATA_W-1:0] r_a, r_b, r_c;
   logic signed [SUMA_W-1:0] r_sum_a;
   logic signed [SUMB_W-1:0] r_sum_b;
   logic signed [PROD_W-1:0] r_prod;
   logic signed [DATA_W-1:0] r_alpha, r_beta;
   logic                     r_sat_a;
   logic                     r_sat;
   logic                     r_out_valid;

   logic signed [SUMA_W-1:0] w_sum_a;
   logic signed [SUMB_W-1:0] w_sum_b;
   logic signed [PROD_W-1:0] w_mul_x;
   logic signed [PROD_W-1:0] w_mul_k;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [RND_W-1:0]  w_rnd;

   // Round half toward +inf, then drop the Q17 fraction.
   function automatic logic signed [RND_W-1:0] round_q17(input logic signed [PROD_W-1:0] p);
      logic signed [PROD_W-1:0] t;
      t = (p + HALF_LSB) >>> 17;
      return t[RND_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [RND_W-1:0] x);
      if (x > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
      else if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
      else                  return x[DATA_W-1:0];
   endfunction

   function automatic logic is_clipped(input logic signed [RND_W-1:0] x);
      return (x > SAT_MAX) || (x < SAT_MIN);
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_SUM;
         S_SUM:   w_next = S_MUL_A;
         S_MUL_A: w_next = S_MUL_B;
         S_MUL_B: w_next = S_OUT;
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign in_ready = (r_state == S_IDLE) && reset;

   assign w_sum_a = ({{3{r_a[DATA_W-1]}}, r_a} <<< 1)
                  - {{3{r_b[DATA_W-1]}}, r_b}
                  - {{3{r_c[DATA_W-1]}}, r_c};
   assign w_sum_b = {r_b[DATA_W-1], r_b} - {r_c[DATA_W-1], r_c};

   // The single multiplier: operand and constant are steered by the state.
   assign w_mul_x = (r_state == S_MUL_A)
                  ? {{(PROD_W-SUMA_W){r_sum_a[SUMA_W-1]}}, r_sum_a}
                  : {{(PROD_W-SUMB_W){r_sum_b[SUMB_W-1]}}, r_sum_b};
   assign w_mul_k = (r_state == S_MUL_A)
                  ? {{(PROD_W-COEF_W+1){1'b0}}, K_THIRD}
                  : {{(PROD_W-COEF_W+1){1'b0}}, K_INV_SQRT3};
   assign w_prod  = w_mul_x * w_mul_k;
   assign w_rnd   = round_q17(r_prod);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_sum_a     <= '0;
         r_sum_b     <= '0;
         r_prod      <= '0;
         r_alpha     <= '0;
         r_beta      <= '0;
         r_sat_a     <= 1'b0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a <= a;
                  r_b <= b;
                  r_c <= c;
               end
            end
            S_SUM: begin
               r_sum_a <= w_sum_a;
               r_sum_b <= w_sum_b;
            end
            S_MUL_A: r_prod <= w_prod;
            S_MUL_B: begin
               r_alpha <= sat_data(w_rnd);
               r_sat_a <= is_clipped(w_rnd);
               r_prod  <= w_prod;
            end
            S_OUT: begin
               r_beta      <= sat_data(w_rnd);
               r_sat       <= r_sat_a | is_clipped(w_rnd);
               r_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign alpha     = r_alpha;
   assign beta      = r_beta;
   assign saturated = r_sat;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_clarke.sv
// Self-checking bench for clarke: directed cases, randomized transactions,
// streaming handshake and mid-transform reset against an arithmetic model.
module tb_clarke;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic signed [17:0] a = '0, b = '0, c = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [17:0] alpha, beta;
   logic               out_valid;
   logic               saturated;

   int checks = 0;
   int errors = 0;

   clarke dut (
      .clock     (clock),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .c         (c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alpha     (alpha),
      .beta      (beta),
      .out_valid (out_valid),
      .saturated (saturated)
   );

   always #5 clock = ~clock;

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      return q;
   endfunction

   // alpha = (2a-b-c)/3, beta = (b-c)/sqrt(3) with Q17 constants, round half up, clamp.
   function automatic void model(input int ia, input int ib, input int ic,
                                 output logic signed [17:0] ea,
                                 output logic signed [17:0] eb,
                                 output logic es);
      longint ra, rb;
      ra = floor_div((2 * longint'(ia) - ib - ic) * 43691 + 65536, 131072);
      rb = floor_div((longint'(ib) - ic) * 75674 + 65536, 131072);
      es = 1'b0;
      if (ra > 131071)  begin ra = 131071;  es = 1'b1; end
      if (ra < -131072) begin ra = -131072; es = 1'b1; end
      if (rb > 131071)  begin rb = 131071;  es = 1'b1; end
      if (rb < -131072) begin rb = -131072; es = 1'b1; end
      ea = ra[17:0];
      eb = rb[17:0];
   endfunction

   // Drive one sample, wait for acceptance, return latency and the strobed result.
   task automatic run_txn(input logic signed [17:0] ia, ib, ic,
                          output int lat,
                          output logic signed [17:0] oa, ob,
                          output logic os);
      int k;
      @(negedge clock);
      a = ia; b = ib; c = ic; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clock);
         k++;
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1 lat++;
      end
      oa = alpha;
      ob = beta;
      os = saturated;
   endtask

   task automatic test_reset;
      int seen;
      reset = 1'b0;
      in_valid = 1'b1;
      a = 18'sd3000; b = -18'sd1500; c = -18'sd1500;
      repeat (3) @(negedge clock);
      checks++; if (alpha !== 18'sd0)   begin errors++; $display("FAIL reset_alpha got %0d want 0", alpha); end
      checks++; if (beta !== 18'sd0)    begin errors++; $display("FAIL reset_beta got %0d want 0", beta); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL reset_saturated got %b want 0", saturated); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      seen = 0;
      repeat (7) begin
         @(posedge clock);
         #1 if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_accept strobes %0d want 0", seen); end
   endtask

   task automatic test_directed;
      int tv [5][6] = '{
         '{  3000,   -1500,   -1500,   3000,    0, 0},
         '{     0,    1000,   -1000,      0, 1155, 0},
         '{ -3000,    1500,    1500,  -3000,    0, 0},
         '{131071, -131072, -131072, 131071,    0, 1},
         '{     0,       0,       0,      0,    0, 0}
      };
      int lat;
      logic signed [17:0] oa, ob, ea, eb;
      logic os;
      for (int i = 0; i < 5; i++) begin
         run_txn(18'(tv[i][0]), 18'(tv[i][1]), 18'(tv[i][2]), lat, oa, ob, os);
         ea = 18'(tv[i][3]);
         eb = 18'(tv[i][4]);
         checks++; if (lat !== 4)  begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
         checks++; if (oa !== ea)  begin errors++; $display("FAIL dir%0d_alpha got %0d want %0d", i, oa, ea); end
         checks++; if (ob !== eb)  begin errors++; $display("FAIL dir%0d_beta got %0d want %0d", i, ob, eb); end
         checks++; if (os !== 1'(tv[i][5])) begin errors++; $display("FAIL dir%0d_saturated got %b want %0d", i, os, tv[i][5]); end
         @(posedge clock);
         #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_strobe_width got %b want 0", i, out_valid); end
         checks++; if (alpha !== ea || beta !== eb) begin errors++; $display("FAIL dir%0d_hold got %0d/%0d want %0d/%0d", i, alpha, beta, ea, eb); end
      end
   endtask

   task automatic test_random;
      int lat;
      logic signed [17:0] ia, ib, ic, oa, ob, ea, eb;
      logic os, es;
      logic signed [17:0] ext [4] = '{18'sh1FFFF, 18'sh20000, 18'sh00000, 18'sh3FFFF};
      for (int i = 0; i < 25; i++) begin
         ia = 18'($urandom);
         ib = 18'($urandom);
         ic = 18'($urandom);
         if (i % 5 == 0) begin
            ia = ext[$urandom_range(0, 3)];
            ib = ext[$urandom_range(0, 3)];
            ic = ext[$urandom_range(0, 3)];
         end
         model(int'(ia), int'(ib), int'(ic), ea, eb, es);
         run_txn(ia, ib, ic, lat, oa, ob, os);
         checks++;
         if (lat !== 4 || oa !== ea || ob !== eb || os !== es) begin
            errors++;
            $display("FAIL rand%0d in %0d,%0d,%0d got lat %0d a %0d b %0d s %b want lat 4 a %0d b %0d s %b",
                     i, ia, ib, ic, lat, oa, ob, os, ea, eb, es);
         end
      end
   endtask

   task automatic test_back_to_back;
      int busy, accepts, strobes, acc;
      logic exp_ready;
      logic signed [17:0] ea, eb;
      logic es;
      int q_cyc[$];
      logic signed [17:0] q_a[$], q_b[$];
      logic q_s[$];
      busy = 0; accepts = 0; strobes = 0;
      for (int i = 0; i < 53; i++) begin
         @(negedge clock);
         if (i < 45) begin
            a = 18'($urandom); b = 18'($urandom); c = 18'($urandom);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         exp_ready = (busy == 0);
         checks++;
         if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL b2b_in_ready cycle %0d got %b want %b", i, in_ready, exp_ready);
         end
         if (exp_ready && in_valid) begin
            model(int'(a), int'(b), int'(c), ea, eb, es);
            q_cyc.push_back(i); q_a.push_back(ea); q_b.push_back(eb); q_s.push_back(es);
            accepts++;
            busy = 4;
         end else if (busy > 0) begin
            busy--;
         end
         @(posedge clock);
         #1;
         if (out_valid) begin
            strobes++;
            checks++;
            if (q_cyc.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious_strobe cycle %0d got strobe want none", i);
            end else begin
               acc = q_cyc.pop_front();
               ea = q_a.pop_front(); eb = q_b.pop_front(); es = q_s.pop_front();
               if (i - acc !== 4 || alpha !== ea || beta !== eb || saturated !== es) begin
                  errors++;
                  $display("FAIL b2b_result cycle %0d got lat %0d a %0d b %0d s %b want lat 4 a %0d b %0d s %b",
                           i, i - acc, alpha, beta, saturated, ea, eb, es);
               end
            end
         end
      end
      checks++; if (strobes !== accepts) begin errors++; $display("FAIL b2b_strobe_count got %0d want %0d", strobes, accepts); end
      checks++; if (accepts !== 9)       begin errors++; $display("FAIL b2b_accept_count got %0d want 9", accepts); end
   endtask

   task automatic test_reset_mid;
      int lat, seen;
      logic signed [17:0] oa, ob;
      logic os;
      run_txn(18'sd0, 18'sd1000, -18'sd1000, lat, oa, ob, os);
      checks++; if (ob !== 18'sd1155) begin errors++; $display("FAIL mid_pre_beta got %0d want 1155", ob); end
      @(negedge clock);
      a = 18'sd3000; b = -18'sd1500; c = -18'sd1500; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_pre_ready got %b want 1", in_ready); end
      @(posedge clock);
      #1 in_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b want 0", in_ready); end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", in_ready); end
      checks++; if (alpha !== 18'sd0 || beta !== 18'sd0 || saturated !== 1'b0) begin
         errors++; $display("FAIL mid_outputs got %0d/%0d/%b want 0/0/0", alpha, beta, saturated);
      end
      seen = 0;
      repeat (8) begin
         @(posedge clock);
         #1 if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_strobe got %0d want 0", seen); end
      run_txn(18'sd3000, -18'sd1500, -18'sd1500, lat, oa, ob, os);
      checks++; if (lat !== 4 || oa !== 18'sd3000 || ob !== 18'sd0 || os !== 1'b0) begin
         errors++; $display("FAIL mid_next got lat %0d a %0d b %0d s %b want 4 3000 0 0", lat, oa, ob, os);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
